// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant for a shared one-hot mux.
// Grants are held until done or a tenure timeout; release re-arbitrates with no bubble.
module onehot_rr_arbiter #(
   parameter int REQ_CNT   = 8,
   parameter int IDX_WIDTH = $clog2(REQ_CNT),
   parameter int MAX_HOLD  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [REQ_CNT-1:0]   req,
   input  logic                 done,
   output logic [REQ_CNT-1:0]   gnt,
   output logic [IDX_WIDTH-1:0] gnt_idx,
   output logic                 gnt_vld,
   output logic                 timeout,
   output logic                 err
);

   localparam int HOLD_W   = $clog2(MAX_HOLD) + 1;
   localparam int HOLD_LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
   localparam logic [HOLD_W-1:0] HOLD_LIM_V = HOLD_W'(HOLD_LIM);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t               state_reg;
   logic [IDX_WIDTH-1:0] rr_ptr_reg;
   logic [IDX_WIDTH-1:0] gnt_idx_reg;
   logic [REQ_CNT-1:0]   gnt_reg;
   logic                 gnt_vld_reg;
   logic                 timeout_reg;
   logic                 err_reg;
   logic [HOLD_W-1:0]    hold_cnt_reg;

   logic [IDX_WIDTH-1:0] next_ptr;
   logic [IDX_WIDTH-1:0] arb_ptr;
   logic [IDX_WIDTH-1:0] pick_idx;
   logic [IDX_WIDTH-1:0] pos_idx;
   logic [REQ_CNT-1:0]   pick_onehot;
   logic                 pick_found;
   logic                 hold_expired;
   logic                 release_now;
   int                   pos;

   assign next_ptr     = (gnt_idx_reg == IDX_WIDTH'(REQ_CNT - 1)) ? '0
                                                                 : gnt_idx_reg + IDX_WIDTH'(1);
   assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LIM_V);
   assign release_now  = (state_reg == BUSY) && (done || hold_expired);
   // On release the departing owner's successor becomes the priority start.
   assign arb_ptr      = (state_reg == BUSY) ? next_ptr : rr_ptr_reg;
   assign pick_found   = |req;

   // Scan downward in offset so the closest request at or above arb_ptr wins last.
   always_comb begin
      pick_idx = '0;
      pos      = 0;
      pos_idx  = '0;
      for (int k = REQ_CNT - 1; k >= 0; k--) begin
         pos = int'(arb_ptr) + k;
         if (pos >= REQ_CNT) pos = pos - REQ_CNT;
         pos_idx = IDX_WIDTH'(pos);
         if (req[pos_idx]) pick_idx = pos_idx;
      end
   end

   generate
      for (genvar gi = 0; gi < REQ_CNT; gi++) begin : g_onehot
         assign pick_onehot[gi] = (pick_idx == IDX_WIDTH'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         rr_ptr_reg   <= '0;
         gnt_idx_reg  <= '0;
         gnt_reg      <= '0;
         gnt_vld_reg  <= 1'b0;
         timeout_reg  <= 1'b0;
         err_reg      <= 1'b0;
         hold_cnt_reg <= '0;
      end else begin
         timeout_reg <= 1'b0;
         err_reg     <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (done) begin
                  err_reg <= 1'b1;
               end else if (pick_found) begin
                  state_reg    <= BUSY;
                  gnt_reg      <= pick_onehot;
                  gnt_idx_reg  <= pick_idx;
                  gnt_vld_reg  <= 1'b1;
                  hold_cnt_reg <= '0;
               end
            end
            BUSY: begin
               if (release_now) begin
                  rr_ptr_reg   <= next_ptr;
                  timeout_reg  <= !done;
                  hold_cnt_reg <= '0;
                  if (pick_found) begin
                     gnt_reg     <= pick_onehot;
                     gnt_idx_reg <= pick_idx;
                  end else begin
                     state_reg   <= IDLE;
                     gnt_reg     <= '0;
                     gnt_idx_reg <= '0;
                     gnt_vld_reg <= 1'b0;
                  end
               end else if (hold_cnt_reg != '1) begin
                  hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign gnt     = gnt_reg;
   assign gnt_idx = gnt_idx_reg;
   assign gnt_vld = gnt_vld_reg;
   assign timeout = timeout_reg;
   assign err     = err_reg;

endmodule

// File: doc/onehot_rr_arbiter.md
ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

Interface
REQ-001 The block SHALL have parameter REQ_CNT, default 8, giving the number of requesters (2..64).
REQ-002 The block SHALL have parameter IDX_WIDTH, default log2(REQ_CNT), giving the width of the binary grant index.
REQ-003 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum grant tenure in cycles; 0 disables the timeout.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port req, input, REQ_CNT bits: request vector; bit i asserted means requester i wants the shared one-hot mux resource.
REQ-007 The block SHALL have port done, input, 1 bit: single-cycle release pulse from the current owner.
REQ-008 The block SHALL have port gnt, output, REQ_CNT bits: registered one-hot grant, driving the select of the shared one-hot mux.
REQ-009 The block SHALL have port gnt_idx, output, IDX_WIDTH bits: registered binary index of the asserted gnt bit.
REQ-010 The block SHALL have port gnt_vld, output, 1 bit: registered; high while any gnt bit is set.
REQ-011 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle pulse on done while idle.

Function
REQ-013 The block SHALL implement two states: IDLE (no grant) and BUSY (grant held).
REQ-014 In IDLE with req != 0, the block SHALL select the first set req bit at or above rr_ptr, wrapping modulo REQ_CNT, and enter BUSY.
REQ-015 The selected grant SHALL appear on gnt, gnt_idx and gnt_vld in the cycle after req is sampled (1-cycle latency).
REQ-016 In IDLE with req == 0, all outputs SHALL remain 0.
REQ-017 In BUSY, gnt and gnt_idx SHALL remain constant regardless of req changes, including the owner dropping its req.
REQ-018 In BUSY, a release SHALL occur on done, or when hold_cnt == MAX_HOLD-1 with MAX_HOLD != 0.
REQ-019 On a release, rr_ptr SHALL be set to (owner+1) mod REQ_CNT.
REQ-020 On a release, arbitration SHALL be performed in the same cycle using the new rr_ptr; the old owner has lowest priority.
REQ-021 If the release arbitration finds req != 0, the new grant SHALL appear next cycle with gnt_vld held high (back-to-back, no bubble).
REQ-022 If the release arbitration finds req == 0, the block SHALL return to IDLE and clear gnt, gnt_idx and gnt_vld next cycle.
REQ-023 hold_cnt SHALL be cleared on every new grant and SHALL increment each BUSY cycle, saturating; its width is log2(MAX_HOLD)+1.
REQ-024 A timeout release SHALL pulse timeout for one cycle, aligned with the cycle in which gnt changes or clears.
REQ-025 If done and the timeout condition occur in the same cycle, the release SHALL be treated as done and timeout SHALL NOT pulse.
REQ-026 A done pulse in IDLE SHALL pulse err for one cycle and SHALL NOT change state or rr_ptr.
REQ-027 gnt SHALL always be zero or one-hot, and gnt_idx SHALL always equal the bit position of gnt (0 when gnt == 0).
REQ-028 rr_ptr wrap-around SHALL be exact: owner REQ_CNT-1 sets rr_ptr to 0.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, rr_ptr=0, hold_cnt=0, gnt=0, gnt_idx=0, gnt_vld=0, timeout=0, err=0.
REQ-030 Reset mid-grant SHALL drop the grant immediately; after reset release, the first arbitration SHALL start from rr_ptr=0.

Verification
REQ-031 Verification SHALL cover basic grant: REQ_CNT=8, req=8'h24 from reset -> next cycle gnt=8'h04, gnt_idx=2, gnt_vld=1.
REQ-032 Verification SHALL cover round-robin: req=8'h24 held, done pulses -> grants 2,5,2,5 with no gnt_vld gap.
REQ-033 Verification SHALL cover wrap-around: owner 7 with req=8'h81 on done -> gnt_idx=0.
REQ-034 Verification SHALL cover timeout: MAX_HOLD=16, owner 3, no done -> gnt held 16 cycles, then timeout pulses once and the grant moves to the next requester or clears.
REQ-035 Verification SHALL cover simultaneous done and timeout -> no timeout pulse; done in IDLE -> err=1 for one cycle with outputs unchanged.
REQ-036 Verification SHALL cover reset during BUSY -> all outputs 0 immediately; after release, req=8'hFF -> gnt_idx=0.
